// File: rtl/prbs_pkg.sv
// Shared PRBS-15 definitions for the pattern/PRBS transmitter and the receive-side checker.
// Optional PRBS_ERR_INJ_EN build macro is consumed by pattern_prbs_tx and its interface.
package prbs_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PATTERN = 2'd2,
    PRBS    = 2'd3
  } tx_state_t;

  localparam int unsigned PRBS15_TAP_A = 14;
  localparam int unsigned PRBS15_TAP_B = 13;
  localparam int unsigned PRBS15_WIDTH = 15;

  localparam logic [PRBS15_WIDTH-1:0] PRBS15_DEFAULT_SEED = 15'h7FFF;

  // An all-zero LFSR state locks up, so substitute the smallest legal seed.
  function automatic logic [PRBS15_WIDTH-1:0] prbs15_safe_seed(input logic [PRBS15_WIDTH-1:0] s);
    return (s == '0) ? 15'h0001 : s;
  endfunction

endpackage

// File: rtl/pattern_prbs_tx_if.sv
// Control/serial bundle between a stimulus master and pattern_prbs_tx.
// err_inj exists only when PRBS_ERR_INJ_EN is defined.
interface pattern_prbs_tx_if;
  logic        start;
  logic        stop;
  logic        en;
  logic [31:0] pattern_in;
  logic        data;
  logic        data_valid;
  logic        pattern_done;
  logic        busy;
`ifdef PRBS_ERR_INJ_EN
  logic        err_inj;
`endif

  modport master (
`ifdef PRBS_ERR_INJ_EN
    output err_inj,
`endif
    output start, stop, en, pattern_in,
    input  data, data_valid, pattern_done, busy
  );

  modport slave (
`ifdef PRBS_ERR_INJ_EN
    input  err_inj,
`endif
    input  start, stop, en, pattern_in,
    output data, data_valid, pattern_done, busy
  );
endinterface

// File: rtl/prbs15_lfsr.sv
// Fibonacci PRBS-15 (x^15+x^14+1) generator; bit_out is the MSB shifted out next.
// Shared by the transmitter and the receive-side checker.
module prbs15_lfsr
  import prbs_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [PRBS15_WIDTH-1:0] seed,
  input  logic                    advance,
  output logic                    bit_out
);

  logic [PRBS15_WIDTH-1:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      lfsr <= prbs15_safe_seed(seed);
    end else if (advance) begin
      lfsr <= {lfsr[PRBS15_WIDTH-2:0], lfsr[PRBS15_TAP_A] ^ lfsr[PRBS15_TAP_B]};
    end
  end

  assign bit_out = lfsr[PRBS15_TAP_A];

endmodule

// File: rtl/pattern_prbs_tx.sv
// Serializes a latched 4-byte pattern N_REPEAT times MSB-first, then a free-running PRBS-15.
// Build macro PRBS_ERR_INJ_EN adds err_inj for single-bit error injection in PRBS.
module pattern_prbs_tx
  import prbs_pkg::*;
#(
  parameter int unsigned             N_REPEAT  = 2,
  parameter logic [PRBS15_WIDTH-1:0] PRBS_SEED = PRBS15_DEFAULT_SEED
) (
  input logic               clk,
  input logic               rst,
  pattern_prbs_tx_if.slave  bus
);

  localparam logic [7:0] LAST_REP = 8'(N_REPEAT - 1);

  tx_state_t   state, next_state;
  logic [31:0] shadow;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [7:0]  rep_cnt;
  logic [4:0]  bit_idx;
  logic        last_bit;
  logic        capture, clear_cnt, shift_pat, adv_prbs;
  logic        lfsr_bit, inject;
  logic        data_q, valid_q, done_q, busy_q;

  assign last_bit = (bit_cnt == 3'd7) && (byte_cnt == 2'd3) && (rep_cnt == LAST_REP);
  assign bit_idx  = 5'd31 - {byte_cnt, bit_cnt};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (bus.stop) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) next_state = LOAD;
        LOAD:    next_state = PATTERN;
        PATTERN: if (bus.en && last_bit) next_state = PRBS;
        PRBS:    next_state = PRBS;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    capture   = 1'b0;
    clear_cnt = 1'b0;
    shift_pat = 1'b0;
    adv_prbs  = 1'b0;
    if (!bus.stop) begin
      case (state)
        IDLE:    capture   = bus.start;
        LOAD:    clear_cnt = 1'b1;
        PATTERN: shift_pat = bus.en;
        PRBS:    adv_prbs  = bus.en;
        default: ;
      endcase
    end
  end

  prbs15_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (capture),
    .seed    (PRBS_SEED),
    .advance (adv_prbs),
    .bit_out (lfsr_bit)
  );

`ifdef PRBS_ERR_INJ_EN
  logic err_q, err_pend;

  // A new rising edge wins over consumption so back-to-back pulses each inject once.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q    <= 1'b0;
      err_pend <= 1'b0;
    end else begin
      err_q <= bus.err_inj;
      if (bus.stop)                      err_pend <= 1'b0;
      else if (bus.err_inj && !err_q)    err_pend <= 1'b1;
      else if (adv_prbs)                 err_pend <= 1'b0;
    end
  end

  assign inject = err_pend;
`else
  assign inject = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      rep_cnt  <= '0;
      data_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      busy_q <= (next_state != IDLE);
      if (bus.stop) begin
        data_q  <= 1'b0;
        valid_q <= 1'b0;
      end
      if (capture) begin
        shadow <= bus.pattern_in;
        done_q <= 1'b0;
      end
      if (clear_cnt) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        rep_cnt  <= '0;
      end
      if (shift_pat) begin
        data_q  <= shadow[bit_idx];
        valid_q <= 1'b1;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + 2'd1;
        if (bit_cnt == 3'd7 && byte_cnt == 2'd3) rep_cnt <= rep_cnt + 8'd1;
        if (last_bit) done_q <= 1'b1;
      end
      if (adv_prbs) begin
        data_q  <= lfsr_bit ^ inject;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.data         = data_q;
  assign bus.data_valid   = valid_q;
  assign bus.pattern_done = done_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_pattern_prbs_tx.sv
// Randomized bench for pattern_prbs_tx against a bit-stream model (pattern bits + PRBS recurrence).
// Define PRBS_ERR_INJ_EN to also exercise error injection.
module tb_pattern_prbs_tx;

  localparam int unsigned NREP      = 2;
  localparam logic [14:0] SEED      = 15'h7FFF;
  localparam int unsigned NPAT      = 32 * NREP;
  localparam int unsigned PERIOD    = 32767;
  localparam int unsigned PRBS_LONG = PERIOD + 20;
  localparam int unsigned MAXB      = NPAT + PRBS_LONG;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pattern_prbs_tx_if bus ();

  pattern_prbs_tx #(.N_REPEAT(NREP), .PRBS_SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          exp_bits [MAXB];
  int unsigned k;
  bit          inv_pending = 1'b0;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at bit %0d: got=%b expected=%b", tag, k, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pattern bits by rotation; PRBS by o[n+15] = o[n] ^ o[n+1] starting from the seed bits MSB-first.
  function automatic void build_model(input logic [31:0] pat);
    logic [31:0] p;
    logic [14:0] s;
    p = pat;
    for (int unsigned i = 0; i < NPAT; i++) begin
      exp_bits[i] = p[31];
      p = {p[30:0], p[31]};
    end
    s = SEED;
    for (int unsigned j = 0; j < 15; j++) begin
      exp_bits[NPAT + j] = s[14];
      s = s << 1;
    end
    for (int unsigned j = 15; j < PRBS_LONG; j++)
      exp_bits[NPAT + j] = exp_bits[NPAT + j - 15] ^ exp_bits[NPAT + j - 14];
  endfunction

  task automatic start_run(input logic [31:0] pat);
    build_model(pat);
    bus.pattern_in = pat;
    bus.start      = 1'b1;
    bus.en         = 1'($urandom_range(0, 1));
    tick();
    check_eq("start_busy", bus.busy, 1'b1);
    check_eq("start_done_clr", bus.pattern_done, 1'b0);
    bus.pattern_in = $urandom;
    bus.en         = 1'($urandom_range(0, 1));
    tick();
    bus.start = 1'b0;
    check_eq("load_valid", bus.data_valid, 1'b0);
    k = 0;
  endtask

  task automatic send_bits(input int unsigned n, input bit rand_en);
    int unsigned sent;
    int unsigned cycles;
    logic        en_v, prev_d, prev_v, exp_b;
    logic [3:0]  seq;
    sent   = 0;
    cycles = 0;
    seq    = 4'b1001;
    while (sent < n && cycles < 4 * n + 16) begin
      if (!rand_en)        en_v = 1'b1;
      else if (cycles < 4) en_v = seq[3];
      else                 en_v = 1'($urandom_range(0, 1));
      seq    = seq << 1;
      prev_d = bus.data;
      prev_v = bus.data_valid;
      bus.en         = en_v;
      bus.pattern_in = $urandom;
      tick();
      cycles++;
      if (en_v) begin
        exp_b = exp_bits[k];
        if (k >= NPAT && inv_pending) begin
          exp_b       = ~exp_b;
          inv_pending = 1'b0;
        end
        check_eq("bit", bus.data, exp_b);
        check_eq("valid", bus.data_valid, 1'b1);
        check_eq("done", bus.pattern_done, (k + 1 >= NPAT));
        if (k >= NPAT + PERIOD && k < NPAT + PERIOD + 15)
          check_eq("period_wrap", bus.data, exp_bits[k - PERIOD]);
        k++;
        sent++;
      end else begin
        check_eq("hold_data", bus.data, prev_d);
        check_eq("hold_valid", bus.data_valid, prev_v);
      end
      check_eq("busy_run", bus.busy, 1'b1);
    end
    check_eq("bit_budget", (sent >= n), 1'b1);
  endtask

  task automatic expect_idle(input string tag, input logic done_exp);
    check_eq({tag, "_data"},  bus.data,         1'b0);
    check_eq({tag, "_valid"}, bus.data_valid,   1'b0);
    check_eq({tag, "_busy"},  bus.busy,         1'b0);
    check_eq({tag, "_done"},  bus.pattern_done, done_exp);
  endtask

`ifdef PRBS_ERR_INJ_EN
  task automatic inject_error();
    logic prev_d;
    prev_d      = bus.data;
    bus.en      = 1'b0;
    bus.err_inj = 1'b1;
    tick();
    check_eq("inj_hold", bus.data, prev_d);
    bus.err_inj = 1'b0;
    inv_pending = 1'b1;
  endtask
`endif

  initial begin
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.en         = 1'b1;
    bus.pattern_in = '0;
`ifdef PRBS_ERR_INJ_EN
    bus.err_inj    = 1'b0;
`endif
    k   = 0;
    rst = 1'b1;
    repeat (5) tick();
    expect_idle("reset", 1'b0);
    rst = 1'b0;

    // en ignored in IDLE
    repeat (3) tick();
    expect_idle("idle_en", 1'b0);

    // Full pattern plus one complete PRBS period and a little more
    start_run(32'hA5C3_0FF1);
    send_bits(MAXB, 1'b0);

    bus.stop = 1'b1;
    bus.en   = 1'b1;
    tick();
    bus.stop = 1'b0;
    expect_idle("stop_prbs", 1'b1);

    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    tick();
    expect_idle("start_stop", 1'b1);

    // Random pattern with gapped en, starting 1,0,0,1
    start_run($urandom);
    send_bits(NPAT + 100, 1'b1);
`ifdef PRBS_ERR_INJ_EN
    inject_error();
    send_bits(40, 1'b1);
    inject_error();
    send_bits(10, 1'b0);
`endif

    // Abort after 20 pattern bits, then restart from byte0 bit7
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    start_run($urandom);
    send_bits(20, 1'b1);
    bus.stop = 1'b1;
    bus.en   = 1'($urandom_range(0, 1));
    tick();
    bus.stop = 1'b0;
    expect_idle("stop_pat", 1'b0);

    start_run(32'hFFFF_0000);
    send_bits(NPAT + 5, 1'b1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_idle("mid_rst", 1'b0);

    start_run($urandom);
    send_bits(NPAT + 30, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_prbs_tx.md
Name: pattern_prbs_tx

Overview:
- Serial transmit-side stimulus generator for the PRBS-15 / sequence-detector link.
- On start, captures a 4-byte pattern and serializes it N_REPEAT times, MSB-first, one bit per enabled cycle.
- It then switches seamlessly to a free-running PRBS-15 stream until stopped.
- Drives the serial data input of the on-chip sequence detector and the board output pin.

Parameters:
- N_REPEAT, 2, number of complete 4-byte pattern repetitions before PRBS starts (legal range 1..255).
- PRBS_SEED, 15'h7FFF, LFSR value loaded on start (non-zero required; zero is replaced by 15'h0001).

Ports:
- clk  in  1  system clock; everything is synchronous to rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- stop  in  1  synchronous abort to IDLE; has priority over start.
- en  in  1  bit strobe; state advances only when en=1.
- pattern_in  in  32  pattern; byte0 = [31:24] is sent first, byte3 = [7:0] is sent last.
- data  out  1  serial bit.
- data_valid  out  1  high while data carries a pattern or PRBS bit.
- pattern_done  out  1  sticky; set when the last pattern bit has been sent, cleared on start or reset.
- busy  out  1  high in LOAD, PATTERN or PRBS.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, data=0, data_valid=0, pattern_done=0, busy=0, all counters=0, lfsr=PRBS_SEED.
- States: IDLE -> LOAD -> PATTERN -> PRBS. stop returns to IDLE from any state.
- IDLE:
  - On start=1 (stop=0), latch pattern_in into shadow register, load lfsr=PRBS_SEED, clear pattern_done, go to LOAD.
  - en is ignored in IDLE.
- LOAD: one cycle regardless of en; clears bit_cnt (3b), byte_cnt (2b), rep_cnt (8b); goes to PATTERN.
- PATTERN:
  - On each en=1 cycle, data <= shadow[31 - 8*byte_cnt - bit_cnt], data_valid <= 1, and bit_cnt increments.
  - bit_cnt wrapping 7->0 increments byte_cnt. byte_cnt wrapping 3->0 increments rep_cnt.
  - When bit 7 of byte3 is sent with rep_cnt==N_REPEAT-1: set pattern_done, go to PRBS.
  - On en=0 cycles, data and data_valid hold their previous values and no counters change.
- Latency:
  - start at edge T -> LOAD at T+1 -> with en held at 1, the first bit appears on data at edge T+2.
  - Exactly 32*N_REPEAT pattern bits precede the first PRBS bit; no gap bit is inserted.
- PRBS:
  - Polynomial x^15+x^14+1.
  - On each en=1 cycle: data <= lfsr[14]; lfsr <= {lfsr[13:0], lfsr[14]^lfsr[13]}; data_valid stays 1.
  - On en=0 cycles, lfsr and data hold. The sequence period is 32767 bits.
- stop: at the next edge state=IDLE, data_valid=0, data=0, busy=0. pattern_done keeps its value.
- start while busy: ignored. pattern_in changes while busy: ignored (shadow register only).
- Simultaneous start and stop in IDLE: remain in IDLE.
- rst asserted mid-operation: the full reset values above apply on that edge.
- busy is registered; it rises at the edge entering LOAD.

Optional Feature:
- Macro: PRBS_ERR_INJ_EN.
- When defined:
  - Adds input err_inj (1b).
  - A rising edge of err_inj latches a pending flag. The next en=1 bit emitted in PRBS state is inverted on data.
  - The LFSR itself is not disturbed, and the pending flag clears after use.
  - A pending flag is cleared by stop or rst.
- When undefined: the port is absent and data is never inverted.

Decomposition:
- Shared package prbs_pkg holds:
  - state encoding constants (IDLE=2'd0, LOAD=2'd1, PATTERN=2'd2, PRBS=2'd3);
  - PRBS15_TAP_A=14, PRBS15_TAP_B=13, PRBS15_WIDTH=15;
  - default seed 15'h7FFF.
- One sub-module, prbs15_lfsr, with ports clk, rst, load, seed, advance, bit_out. It is reused by the receiver checker.
- The serializer counters and FSM stay in pattern_prbs_tx.

Test Plan:
- Reset with en=1 for 5 cycles -> data=0, data_valid=0, busy=0, pattern_done=0.
- N_REPEAT=2, pattern_in=32'hA5C3_0FF1, start, en=1 -> first 8 bits are 1,0,1,0,0,1,0,1; 64 pattern bits total; pattern_done rises with the 64th bit; the 65th bit equals seed bit 14 (=1).
- PRBS run with seed 15'h7FFF, 32767 en cycles -> lfsr returns to 15'h7FFF; the stream matches a reference model bit-exactly.
- en toggled 1,0,0,1 during PATTERN -> data holds on en=0 cycles; total bit count is still 32*N_REPEAT.
- stop asserted at pattern bit 20 -> next cycle IDLE, data_valid=0. A restart with 32'hFFFF_0000 re-sends from byte0 bit7.
- With PRBS_ERR_INJ_EN defined: err_inj pulse in PRBS state -> exactly one inverted bit versus the model; subsequent bits match.
